// File: rtl/stack_unit_if.sv
// Bundle of control inputs and status outputs for stack_unit.
// The master drives push/pop/data_in and reads back the top-of-stack and status flags.
interface stack_unit_if #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned NWORDS = 16
);
  localparam int unsigned CW = $clog2(NWORDS + 1);

  logic             push;
  logic             pop;
  logic             irq_frame;
  logic             adj_en;
  logic             clr_err;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             top_irq;
  logic [CW-1:0]    count;
  logic [CW-1:0]    irq_nest;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, irq_frame, adj_en, clr_err, data_in,
    input  data_out, top_irq, count, irq_nest, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, irq_frame, adj_en, clr_err, data_in,
    output data_out, top_irq, count, irq_nest, full, empty, overflow, underflow
  );
endinterface

// File: rtl/stack_unit.sv
// Call/return stack with interrupt-frame tagging, replace-top (push+pop) and sticky
// overflow/underflow flags. The top entry is presented combinationally.
module stack_unit #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned NWORDS = 16,
  parameter int unsigned ADJ    = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  stack_unit_if.slave bus_io
);
  localparam int unsigned CW = $clog2(NWORDS + 1);
  localparam int unsigned AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef logic [WIDTH:0] entry_t;  // {tag, data}

  entry_t        mem_q [NWORDS];
  logic [CW-1:0] sp_q, sp_d;
  logic [CW-1:0] nest_q, nest_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          full, empty;
  logic          replace, push_acc, pop_acc, ovf_evt, unf_evt, we;
  logic [AW-1:0] top_idx, wr_idx;
  entry_t        top_entry, wr_entry;
  logic          top_tag;

  assign empty     = (sp_q == '0);
  assign full      = (sp_q == CW'(NWORDS));
  assign top_idx   = AW'(sp_q - CW'(1));
  assign top_entry = mem_q[top_idx];
  assign top_tag   = top_entry[WIDTH];

  always_comb begin
    // push+pop on an empty stack degrades to a plain push
    replace  = bus_io.push & bus_io.pop & ~empty;
    push_acc = bus_io.push & ~replace & ~full;
    pop_acc  = bus_io.pop & ~bus_io.push & ~empty;
    ovf_evt  = bus_io.push & ~replace & full;
    unf_evt  = bus_io.pop & ~bus_io.push & empty;
    we       = push_acc | replace;
    wr_idx   = replace ? top_idx : AW'(sp_q);
    wr_entry = {bus_io.irq_frame, bus_io.data_in};

    sp_d = sp_q;
    if (push_acc) begin
      sp_d = sp_q + CW'(1);
    end else if (pop_acc) begin
      sp_d = sp_q - CW'(1);
    end

    nest_d = nest_q + CW'(we & bus_io.irq_frame) - CW'((pop_acc | replace) & top_tag);
    ovf_d  = ovf_evt | (ovf_q & ~bus_io.clr_err);
    unf_d  = unf_evt | (unf_q & ~bus_io.clr_err);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q   <= '0;
      nest_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      nest_q <= nest_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage is intentionally not reset; sp_q alone defines validity.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[wr_idx] <= wr_entry;
    end
  end

  always_comb begin
    bus_io.data_out = '0;
    bus_io.top_irq  = 1'b0;
    if (!empty) begin
      bus_io.top_irq  = top_tag;
      bus_io.data_out = top_entry[WIDTH-1:0]
                        - ((top_tag & bus_io.adj_en) ? WIDTH'(ADJ) : WIDTH'(0));
    end
  end

  assign bus_io.count     = sp_q;
  assign bus_io.irq_nest  = nest_q;
  assign bus_io.full      = full;
  assign bus_io.empty     = empty;
  assign bus_io.overflow  = ovf_q;
  assign bus_io.underflow = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// Randomised bench for stack_unit against a queue-based stack model,
// plus directed sequences with literal expectations.
module tb_stack_unit;
  localparam int unsigned WIDTH  = 10;
  localparam int unsigned NWORDS = 16;
  localparam int unsigned ADJ    = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_unit_if #(.WIDTH(WIDTH), .NWORDS(NWORDS)) bus ();

  stack_unit #(
    .WIDTH (WIDTH),
    .NWORDS(NWORDS),
    .ADJ   (ADJ)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH:0] mstk[$];
  bit             m_ovf = 0;
  bit             m_unf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_nest();
    int n = 0;
    foreach (mstk[i]) if (mstk[i][WIDTH]) n++;
    return n;
  endfunction

  task automatic compare();
    logic [WIDTH-1:0] d;
    logic             t;
    int               sz;
    sz = mstk.size();
    d  = '0;
    t  = 1'b0;
    if (sz > 0) begin
      d = mstk[sz-1][WIDTH-1:0];
      t = mstk[sz-1][WIDTH];
      if (t && bus.adj_en) d = d - WIDTH'(ADJ);
    end
    chk("data_out", 32'(bus.data_out), 32'(d));
    chk("top_irq", 32'(bus.top_irq), 32'(t));
    chk("count", 32'(bus.count), 32'(sz));
    chk("irq_nest", 32'(bus.irq_nest), 32'(m_nest()));
    chk("full", 32'(bus.full), 32'(sz == NWORDS));
    chk("empty", 32'(bus.empty), 32'(sz == 0));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
  endtask

  task automatic model_step();
    logic [WIDTH:0] e;
    int             sz;
    bit             oe, ue;
    e  = {bus.irq_frame, bus.data_in};
    sz = mstk.size();
    oe = 0;
    ue = 0;
    if (bus.push && bus.pop && sz > 0) begin
      void'(mstk.pop_back());
      mstk.push_back(e);
    end else if (bus.push) begin
      if (sz < NWORDS) mstk.push_back(e);
      else oe = 1;
    end else if (bus.pop) begin
      if (sz > 0) void'(mstk.pop_back());
      else ue = 1;
    end
    m_ovf = oe || (m_ovf && !bus.clr_err);
    m_unf = ue || (m_unf && !bus.clr_err);
  endtask

  // Called just after a rising edge: drive, check mid-cycle, update model, advance.
  task automatic step(input bit p, input bit q, input bit irq, input bit adj, input bit clr,
                      input logic [WIDTH-1:0] din);
    bus.push      = p;
    bus.pop       = q;
    bus.irq_frame = irq;
    bus.adj_en    = adj;
    bus.clr_err   = clr;
    bus.data_in   = din;
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit adj);
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.irq_frame = 1'b0;
    bus.adj_en    = adj;
    bus.clr_err   = 1'b0;
    bus.data_in   = '0;
    #1;
  endtask

  task automatic rand_steps(input int n);
    int pp, pq;
    for (int i = 0; i < n; i++) begin
      case ((i / 250) % 4)
        0:       begin pp = 70; pq = 30; end
        1:       begin pp = 25; pq = 75; end
        2:       begin pp = 50; pq = 50; end
        default: begin pp = 90; pq = 15; end
      endcase
      step($urandom_range(99) < pp, $urandom_range(99) < pq, $urandom_range(99) < 30,
           $urandom_range(1) == 1, $urandom_range(99) < 5, WIDTH'($urandom));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle(0);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_unf", 32'(bus.underflow), 32'd0);

    // Fill, then overflow
    for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, 0, WIDTH'(i));
    idle(0);
    chk("fill_count", 32'(bus.count), 32'd16);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_top", 32'(bus.data_out), 32'h010);
    step(1, 0, 0, 0, 0, 10'h3FF);
    idle(0);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd16);
    chk("ovf_top", 32'(bus.data_out), 32'h010);

    // Drain, underflow, clear
    for (int i = 0; i < 16; i++) begin
      idle(0);
      chk("pop_seq", 32'(bus.data_out), 32'(16 - i));
      step(0, 1, 0, 0, 0, '0);
    end
    idle(0);
    chk("drain_empty", 32'(bus.empty), 32'd1);
    step(0, 1, 0, 0, 0, '0);
    idle(0);
    chk("unf_flag", 32'(bus.underflow), 32'd1);
    chk("unf_count", 32'(bus.count), 32'd0);
    step(0, 0, 0, 0, 1, '0);
    idle(0);
    chk("clr_ovf", 32'(bus.overflow), 32'd0);
    chk("clr_unf", 32'(bus.underflow), 32'd0);

    // Tagged entry with adjust
    step(1, 0, 1, 1, 0, 10'h100);
    idle(1);
    chk("adj_data", 32'(bus.data_out), 32'h0FF);
    chk("adj_tag", 32'(bus.top_irq), 32'd1);
    chk("adj_nest", 32'(bus.irq_nest), 32'd1);
    idle(0);
    chk("noadj_data", 32'(bus.data_out), 32'h100);
    step(0, 1, 0, 0, 0, '0);
    idle(0);
    chk("adj_pop_nest", 32'(bus.irq_nest), 32'd0);

    // Replace-top
    step(1, 0, 0, 0, 0, 10'h005);
    step(1, 0, 1, 0, 0, 10'h006);
    step(1, 1, 0, 0, 0, 10'h007);
    idle(0);
    chk("rep_count", 32'(bus.count), 32'd2);
    chk("rep_data", 32'(bus.data_out), 32'h007);
    chk("rep_tag", 32'(bus.top_irq), 32'd0);
    chk("rep_nest", 32'(bus.irq_nest), 32'd0);
    step(0, 1, 0, 0, 0, '0);
    step(0, 1, 0, 0, 0, '0);
    step(1, 1, 0, 0, 0, 10'h0AA);
    idle(0);
    chk("rep_empty_count", 32'(bus.count), 32'd1);
    chk("rep_empty_unf", 32'(bus.underflow), 32'd0);
    step(0, 1, 0, 0, 0, '0);

    rand_steps(4000);

    // Asynchronous reset mid-burst: count=5 with overflow pending
    step(0, 0, 0, 0, 1, '0);
    while (mstk.size() < NWORDS) step(1, 0, $urandom_range(1), 0, 0, WIDTH'($urandom));
    step(1, 0, 0, 0, 0, 10'h3FF);
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0, 0, '0);
    idle(0);
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    chk("pre_rst_ovf", 32'(bus.overflow), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_empty", 32'(bus.empty), 32'd1);
    chk("arst_full", 32'(bus.full), 32'd0);
    chk("arst_data", 32'(bus.data_out), 32'd0);
    chk("arst_tag", 32'(bus.top_irq), 32'd0);
    chk("arst_nest", 32'(bus.irq_nest), 32'd0);
    chk("arst_ovf", 32'(bus.overflow), 32'd0);
    chk("arst_unf", 32'(bus.underflow), 32'd0);
    mstk.delete();
    m_ovf = 0;
    m_unf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_steps(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
Parametrised hardware call/return stack for the CPU. It is the successor of the single-port push/pop stack. It adds full/empty and occupancy reporting, sticky overflow/underflow errors, per-entry interrupt-frame tagging with a configurable return-address adjust, and same-cycle push+pop (replace-top). It sits beside the PC logic: the control unit pushes return addresses on call/interrupt and pops on return.

Parameters:
WIDTH, 10, data word width in bits (return-address width)
NWORDS, 16, stack depth in entries; must be >= 2
ADJ, 1, value subtracted from a tagged entry on read-out (interrupt return correction)
CW, $clog2(NWORDS+1), occupancy counter width; derived, not overridden

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
push  in  1  push data_in this cycle
pop  in  1  pop top entry this cycle
irq_frame  in  1  tag the entry pushed this cycle as an interrupt frame
adj_en  in  1  enable ADJ correction on tagged entries at data_out
clr_err  in  1  clear sticky error flags
data_in  in  WIDTH  word to push
data_out  out  WIDTH  current top of stack (after adjust)
top_irq  out  1  tag bit of current top entry
count  out  CW  number of valid entries, 0..NWORDS
irq_nest  out  CW  number of tagged entries currently on the stack
full  out  1  count == NWORDS
empty  out  1  count == 0
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Storage: NWORDS x (WIDTH+1) register array, holding data plus tag. A stack pointer sp (CW bits) equals count and points at the next free slot. Top = entry[sp-1].
- Reset (reset low, async): sp=0, irq_nest=0, overflow=0, underflow=0. Array contents are not cleared. Outputs: data_out=0, top_irq=0, count=0, full=0, empty=1.
- data_out, top_irq: combinational from the top entry. Zero when empty. data_out = data - ADJ when top tag=1 and adj_en=1, else data. Subtraction wraps modulo 2^WIDTH.
- All state updates occur on the rising clk edge. Effects are visible on outputs in the following cycle (1-cycle latency).
- push only, not full: entry[sp] <= {irq_frame, data_in}; sp+1; irq_nest+irq_frame.
- push only, full: no write, sp unchanged, overflow <= 1.
- pop only, not empty: sp-1; irq_nest decrements if the popped tag=1. The popped value is data_out in the cycle pop is asserted.
- pop only, empty: no change, underflow <= 1.
- push and pop, not empty: replace top. entry[sp-1] <= {irq_frame, data_in}; sp unchanged; irq_nest adjusted by (irq_frame - old tag). No overflow, even when full.
- push and pop, empty: treated as push only; no underflow.
- irq_frame is ignored when push=0.
- clr_err clears overflow and underflow. If a new error event occurs in the same cycle, the event wins and the flag stays/sets to 1.
- irq_nest <= count at all times. It never goes negative or exceeds NWORDS.
- Array write enable is asserted only on an accepted push or replace. No writes on rejected operations.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, data_out=0, overflow=underflow=0.
- With NWORDS=16, push 0x001..0x010 on 16 cycles -> count=16, full=1, data_out=0x010. Push 0x3FF once more -> overflow=1, count=16, data_out still 0x010.
- Pop 16 times from full -> data_out sequence 0x010,0x00F,...,0x001, then empty=1. A 17th pop -> underflow=1, count=0. Then clr_err -> both flags 0 next cycle.
- Push 0x100 with irq_frame=1, adj_en=1 -> data_out=0x0FF, top_irq=1, irq_nest=1. With adj_en=0 -> data_out=0x100. Pop -> irq_nest=0.
- Stack holds [0x005, 0x006(tagged)]; push+pop with data_in=0x007, irq_frame=0 -> count=2, data_out=0x007, top_irq=0, irq_nest=0. Push+pop while empty -> count=1, no underflow.
- Drive reset low mid-burst (count=5, overflow=1) asynchronously between edges -> outputs go to reset values immediately, without waiting for a clk edge.
